// File: rtl/fir_seq_pkg.sv
// Shared types and default sizing for the band-pass FIR channel sequencer.
// These defaults are also used by the beamformer top.
package fir_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FEED  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } fir_state_e;

   localparam int FIR_ADDR_W      = 11;
   localparam int FIR_NUM_SAMPLES = 2048;
   localparam int FIR_RD_LAT      = 2;
   localparam int FIR_DRAIN_MAX   = 255;

endpackage

// File: rtl/fir_seq_vpipe.sv
// DEPTH-deep valid delay line with an async active-low clear.
// It aligns a RAM read enable with the RAM's q output.
module fir_seq_vpipe #(
   parameter int DEPTH = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic vld_i,
   output logic vld_o
);

   logic [DEPTH-1:0] pipe_q;
   logic [DEPTH-1:0] pipe_d;

   always_comb begin
      pipe_d = (pipe_q << 1) | DEPTH'(vld_i);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipe_q <= '0;
      end else begin
         pipe_q <= pipe_d;
      end
   end

   assign vld_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/fir_seq_ctrl.sv
// FIR channel sequencer: input RAM -> BP filter -> output RAM, one block per go.
// Define FIR_SEQ_WDOG_EN to enable the DRAIN watchdog; this sets err on a timeout.
//
// state | meaning
// IDLE  | waiting for go
// FEED  | reading input RAM, one word per clock
// DRAIN | reads finished, collecting remaining filter outputs
// DONE  | one-cycle done pulse, then back to IDLE
module fir_seq_ctrl
   import fir_seq_pkg::*;
#(
   parameter int ADDR_W      = FIR_ADDR_W,
   parameter int NUM_SAMPLES = FIR_NUM_SAMPLES,
   parameter int RD_LAT      = FIR_RD_LAT
`ifdef FIR_SEQ_WDOG_EN
  ,parameter int DRAIN_MAX   = FIR_DRAIN_MAX
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              go_i,
   output logic [ADDR_W-1:0] in_addr_o,
   output logic              in_rd_o,
   output logic              sink_valid_o,
   input  logic              src_valid_i,
   output logic [ADDR_W-1:0] out_addr_o,
   output logic              out_wr_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_SAMPLES - 1);
   localparam logic [ADDR_W:0]   NUM_CNT   = (ADDR_W+1)'(NUM_SAMPLES);
   localparam logic [ADDR_W:0]   LAST_CNT  = (ADDR_W+1)'(NUM_SAMPLES - 1);

   fir_state_e        state_q, state_d;
   logic [ADDR_W-1:0] in_addr_q, in_addr_d;
   logic [ADDR_W-1:0] out_addr_q, out_addr_d;
   logic [ADDR_W:0]   out_cnt_q, out_cnt_d;

`ifdef FIR_SEQ_WDOG_EN
   localparam int              WD_W    = $clog2(DRAIN_MAX + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(DRAIN_MAX - 1);

   logic [WD_W-1:0] wd_q, wd_d;
   logic            err_q, err_d;
`endif

   always_comb begin
      state_d    = state_q;
      in_addr_d  = in_addr_q;
      out_addr_d = out_addr_q;
      out_cnt_d  = out_cnt_q;
      in_rd_o    = 1'b0;
      out_wr_o   = 1'b0;
      busy_o     = 1'b0;
      done_o     = 1'b0;
`ifdef FIR_SEQ_WDOG_EN
      wd_d       = '0;
      err_d      = err_q;
`endif

      // Output writes run in both FEED and DRAIN; beats past the block are dropped.
      if (state_q == FEED || state_q == DRAIN) begin
         busy_o = 1'b1;
         if (src_valid_i && out_cnt_q != NUM_CNT) begin
            out_wr_o  = 1'b1;
            out_cnt_d = out_cnt_q + (ADDR_W+1)'(1);
            if (out_cnt_q != LAST_CNT) begin
               out_addr_d = out_addr_q + ADDR_W'(1);
            end
         end
      end

      case (state_q)
         IDLE: begin
            if (go_i) begin
               state_d    = FEED;
               in_addr_d  = '0;
               out_addr_d = '0;
               out_cnt_d  = '0;
`ifdef FIR_SEQ_WDOG_EN
               err_d      = 1'b0;
`endif
            end
         end
         FEED: begin
            in_rd_o = 1'b1;
            if (in_addr_q == LAST_ADDR) begin
               state_d = DRAIN;
            end else begin
               in_addr_d = in_addr_q + ADDR_W'(1);
            end
         end
         DRAIN: begin
            if (out_cnt_d == NUM_CNT) begin
               state_d = DONE;
`ifdef FIR_SEQ_WDOG_EN
            end else if (!src_valid_i) begin
               if (wd_q == WD_LAST) begin
                  state_d = DONE;
                  err_d   = 1'b1;
               end else begin
                  wd_d = wd_q + WD_W'(1);
               end
`endif
            end
         end
         DONE: begin
            done_o  = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         in_addr_q  <= '0;
         out_addr_q <= '0;
         out_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         in_addr_q  <= in_addr_d;
         out_addr_q <= out_addr_d;
         out_cnt_q  <= out_cnt_d;
      end
   end

`ifdef FIR_SEQ_WDOG_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wd_q  <= '0;
         err_q <= 1'b0;
      end else begin
         wd_q  <= wd_d;
         err_q <= err_d;
      end
   end

   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

   assign in_addr_o  = in_addr_q;
   assign out_addr_o = out_addr_q;

   fir_seq_vpipe #(
      .DEPTH (RD_LAT)
   ) u_vpipe (
      .clk   (clk),
      .rst_n (rst),
      .vld_i (in_rd_o),
      .vld_o (sink_valid_o)
   );

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Randomized bench for fir_seq_ctrl: small block (8 samples) vs a cycle-count model,
// plus one full 2048-sample block on a second instance.
module tb_fir_seq_ctrl;

   localparam int AW  = 3;
   localparam int N   = 8;
   localparam int RDL = 2;
   localparam int BW  = 11;
   localparam int BN  = 2048;
`ifdef FIR_SEQ_WDOG_EN
   localparam int DMAX = 16;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          go  = 1'b0;
   logic          src = 1'b0;
   logic [AW-1:0] in_addr, out_addr;
   logic          in_rd, sink_valid, out_wr, busy, done, err;

   logic          go_b  = 1'b0;
   logic          src_b = 1'b0;
   logic [BW-1:0] in_addr_b, out_addr_b;
   logic          in_rd_b, sink_b, out_wr_b, busy_b, done_b, err_b;

   always #5 clk = ~clk;

   fir_seq_ctrl #(
      .ADDR_W      (AW),
      .NUM_SAMPLES (N),
      .RD_LAT      (RDL)
`ifdef FIR_SEQ_WDOG_EN
     ,.DRAIN_MAX   (DMAX)
`endif
   ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .go_i         (go),
      .in_addr_o    (in_addr),
      .in_rd_o      (in_rd),
      .sink_valid_o (sink_valid),
      .src_valid_i  (src),
      .out_addr_o   (out_addr),
      .out_wr_o     (out_wr),
      .busy_o       (busy),
      .done_o       (done),
      .err_o        (err)
   );

   fir_seq_ctrl #(
      .ADDR_W      (BW),
      .NUM_SAMPLES (BN),
      .RD_LAT      (2)
   ) u_dut_big (
      .clk          (clk),
      .rst          (rst),
      .go_i         (go_b),
      .in_addr_o    (in_addr_b),
      .in_rd_o      (in_rd_b),
      .sink_valid_o (sink_b),
      .src_valid_i  (src_b),
      .out_addr_o   (out_addr_b),
      .out_wr_o     (out_wr_b),
      .busy_o       (busy_b),
      .done_o       (done_b),
      .err_o        (err_b)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_in_rd"},    32'(in_rd),      0);
      check({tag, "_in_addr"},  32'(in_addr),    0);
      check({tag, "_sink"},     32'(sink_valid), 0);
      check({tag, "_out_wr"},   32'(out_wr),     0);
      check({tag, "_out_addr"}, 32'(out_addr),   0);
      check({tag, "_busy"},     32'(busy),       0);
      check({tag, "_done"},     32'(done),       0);
      check({tag, "_err"},      32'(err),        0);
   endtask

   // Reference model: k = clock index within a block (1 = first read cycle),
   // w = writes so far, kd = clock index of the done pulse once known.
   bit m_active = 0;
   int m_k = 0, m_w = 0, m_kd = 0, m_idle = 0;
   bit m_err = 0;
   bit rd_hist [8];
   bit sv_hist [8];

   always @(negedge clk) begin
      int rd_e, ia_e, oa_e, wr_e, busy_e, done_e;
      if (!rst) begin
         m_active = 0; m_k = 0; m_w = 0; m_kd = 0; m_idle = 0; m_err = 0;
         for (int i = 0; i < 8; i++) begin
            rd_hist[i] = 0;
            sv_hist[i] = 0;
         end
      end else begin
         rd_e   = (m_active && m_k <= N) ? 1 : 0;
         ia_e   = (m_k == 0) ? 0 : ((m_k <= N) ? m_k - 1 : N - 1);
         oa_e   = (m_w < N) ? m_w : N - 1;
         busy_e = (m_active && m_k != m_kd) ? 1 : 0;
         done_e = (m_active && m_k == m_kd) ? 1 : 0;
         wr_e   = (busy_e == 1 && src && m_w < N) ? 1 : 0;

         check("in_rd",      32'(in_rd),      rd_e);
         check("in_addr",    32'(in_addr),    ia_e);
         check("sink_valid", 32'(sink_valid), 32'(rd_hist[RDL-1]));
         check("out_wr",     32'(out_wr),     wr_e);
         check("out_addr",   32'(out_addr),   oa_e);
         check("busy",       32'(busy),       busy_e);
         check("done",       32'(done),       done_e);
         check("err",        32'(err),        32'(m_err));

         for (int i = 7; i > 0; i--) begin
            rd_hist[i] = rd_hist[i-1];
            sv_hist[i] = sv_hist[i-1];
         end
         rd_hist[0] = (rd_e != 0);
         sv_hist[0] = sink_valid;

         if (m_active) begin
            if (wr_e != 0) begin
               m_w++;
               if (m_w == N) m_kd = (m_k + 1 > N + 2) ? m_k + 1 : N + 2;
            end
`ifdef FIR_SEQ_WDOG_EN
            if (m_kd == 0 && m_k > N) begin
               if (src) m_idle = 0;
               else begin
                  m_idle++;
                  if (m_idle == DMAX) begin
                     m_kd  = m_k + 1;
                     m_err = 1;
                  end
               end
            end
`endif
            if (done_e != 0) m_active = 0;
            else m_k++;
         end else if (go) begin
            m_active = 1; m_k = 1; m_w = 0; m_kd = 0; m_idle = 0; m_err = 0;
         end
      end
   end

   // mode 0: filter echoes sink_valid after lat clocks, then extra beats
   // mode 1: random src density; mode 2: random until starve_at writes, then silence
   task automatic run_block(input int mode, input int lat, input int dens,
                            input int extra, input int starve_at, input int rst_at);
      int n, echoed, xtra;
      repeat ($urandom_range(1, 3)) begin
         @(posedge clk); #1;
         go  = 1'b0;
         src = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      go  = 1'b1;
      src = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      go = 1'b0;
      n = 0; echoed = 0; xtra = extra;
      while (m_active && n < 600) begin
         if (rst_at != 0 && m_k == rst_at) begin
            #2 rst = 1'b0;
            #1 check_zero("rst_async");
            @(posedge clk); #1;
            check_zero("rst_hold");
            #1 rst = 1'b1;
            break;
         end
         go = (m_k == m_kd) || ($urandom_range(0, 5) == 0);
         case (mode)
            0: begin
               if (echoed < N) begin
                  src = sv_hist[lat-1];
                  if (src) echoed++;
               end else if (xtra > 0) begin
                  src = 1'b1;
                  xtra--;
               end else begin
                  src = 1'b0;
               end
            end
            1:       src = ($urandom_range(0, 3) < dens);
            default: src = (m_w < starve_at) && ($urandom_range(0, 3) < dens);
         endcase
         @(posedge clk); #1;
         n++;
      end
      check("run_bounded", 32'(n < 600), 1);
      go  = 1'b0;
      src = 1'b0;
   endtask

   bit b_on  = 0;
   bit sb_last = 0;
   int b_rd = 0, b_wr = 0, b_done = 0;

   always @(negedge clk) begin
      if (b_on) begin
         if (in_rd_b) begin
            check("big_in_addr", 32'(in_addr_b), b_rd);
            b_rd++;
         end
         if (out_wr_b) begin
            check("big_out_addr", 32'(out_addr_b), b_wr);
            b_wr++;
         end
         if (done_b) b_done++;
         sb_last = sink_b;
      end
   end

   initial begin
      int n;
      #1 rst = 1'b0;
      #2 check_zero("reset");
      @(posedge clk); #2 rst = 1'b1;

      run_block(0, 3, 0, 0, 0, 0);
      run_block(0, 3, 0, 2, 0, 0);
      for (int i = 0; i < 6; i++)
         run_block(0, $urandom_range(1, 5), 0, $urandom_range(0, 3), 0, 0);
      for (int i = 0; i < 8; i++)
         run_block(1, 0, $urandom_range(1, 4), 0, 0, 0);
      run_block(0, 3, 0, 0, 0, 5);
      run_block(0, 3, 0, 0, 0, 0);
`ifdef FIR_SEQ_WDOG_EN
      run_block(2, 0, 4, 0, 5, 0);
      run_block(2, 0, $urandom_range(1, 4), 0, $urandom_range(0, N - 1), 0);
      run_block(0, 3, 0, 0, 0, 0);
`endif

      b_on = 1;
      @(posedge clk); #1 go_b = 1'b1;
      @(posedge clk); #1 go_b = 1'b0;
      n = 0;
      while (!done_b && n < 3000) begin
         src_b = sb_last;
         @(posedge clk); #1;
         n++;
      end
      check("big_bounded", 32'(n < 3000), 1);
      src_b = 1'b0;
      @(posedge clk); #1;
      check("big_reads",     b_rd, BN);
      check("big_writes",    b_wr, BN);
      check("big_done_cnt",  b_done, 1);
      check("big_out_last",  32'(out_addr_b), BN - 1);
      check("big_in_last",   32'(in_addr_b), BN - 1);
      check("big_busy_idle", 32'(busy_b), 0);
      check("big_err",       32'(err_b), 0);

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
